// File: rtl/regfile_ctrl_param_pkg.sv
// Shared types, bit positions and register-map helpers for the adder-datapath register file.
package regfile_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;

  // Word indices of the fixed registers that follow the operand block
  function automatic int idx_result(input int num_ops);
    return num_ops;
  endfunction

  function automatic int idx_ctrl(input int num_ops);
    return num_ops + 1;
  endfunction

  function automatic int idx_status(input int num_ops);
    return num_ops + 2;
  endfunction

endpackage

// File: rtl/regfile_ctrl_param_if.sv
// AMBA-side write/read channel bundle between the channel logic (master) and the register file (slave).
interface regfile_ctrl_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  i_en_amba_write;
  logic [ADDR_W-1:0]     i_addr_wc;
  logic [DATA_W-1:0]     i_data_wc;
  logic [DATA_W/8-1:0]   i_strb_wc;
  logic [ADDR_W-1:0]     i_addr_rc;
  logic [DATA_W-1:0]     o_data_rc;

  modport master (
    output i_en_amba_write, i_addr_wc, i_data_wc, i_strb_wc, i_addr_rc,
    input  o_data_rc
  );

  modport slave (
    input  i_en_amba_write, i_addr_wc, i_data_wc, i_strb_wc, i_addr_rc,
    output o_data_rc
  );
endinterface

// File: rtl/regfile_ctrl_param_strb_reg.sv
// One byte-strobed data register with asynchronous active-low clear.
module strb_reg #(
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARSTn,
  input  logic                we,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   d,
  output logic [DATA_W-1:0]   q
);

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (strb[b]) q[b*8 +: 8] <= d[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/regfile_ctrl_param.sv
// Register file for the adder datapath: operand regs, RESULT, CTRL, STATUS,
// start pulse generation, IDLE/BUSY/DONE tracking and completion interrupt.
module regfile_ctrl_param
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                      ACLK,
  input  logic                      ARSTn,
  regfile_ctrl_param_if.slave       bus,
  input  logic                      i_result_valid,
  input  logic [DATA_W-1:0]         i_result,
  output logic                      o_start,
  output logic [NUM_OPS*DATA_W-1:0] o_ops,
  output logic                      o_irq,
  output logic                      o_wr_err
);

  localparam logic [ADDR_W-1:0] IDX_RESULT = ADDR_W'(idx_result(NUM_OPS));
  localparam logic [ADDR_W-1:0] IDX_CTRL   = ADDR_W'(idx_ctrl(NUM_OPS));
  localparam logic [ADDR_W-1:0] IDX_STATUS = ADDR_W'(idx_status(NUM_OPS));

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  op_q [NUM_OPS];
  logic [DATA_W-1:0]  result_q;
  logic               done_q, irq_en_q;
  logic               start_p1, wr_err_p1;

  logic wr_vld, lane0, busy;
  logic hit_op, hit_res, hit_ctrl, hit_stat, hit_none;
  logic start_req, start_go, op_we, irq_we, done_w1c, res_go, wr_err_d;

  // A write with no byte lanes enabled is treated as if it never happened
  assign wr_vld   = bus.i_en_amba_write && (|bus.i_strb_wc);
  assign lane0    = bus.i_strb_wc[0];
  assign busy     = (state == ST_BUSY);

  assign hit_op   = bus.i_addr_wc < ADDR_W'(NUM_OPS);
  assign hit_res  = bus.i_addr_wc == IDX_RESULT;
  assign hit_ctrl = bus.i_addr_wc == IDX_CTRL;
  assign hit_stat = bus.i_addr_wc == IDX_STATUS;
  assign hit_none = bus.i_addr_wc > IDX_STATUS;

  assign start_req = wr_vld && hit_ctrl && lane0 && bus.i_data_wc[CTRL_START_BIT];
  assign start_go  = start_req && !busy;
  assign op_we     = wr_vld && hit_op && !busy;
  assign irq_we    = wr_vld && hit_ctrl && lane0;
  assign done_w1c  = wr_vld && hit_stat && lane0 && bus.i_data_wc[STAT_DONE_BIT];
  assign res_go    = busy && i_result_valid;
  assign wr_err_d  = wr_vld && (hit_res || hit_none || (busy && (hit_op || start_req)));

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    strb_reg #(.DATA_W(DATA_W)) u_op (
      .ACLK  (ACLK),
      .ARSTn (ARSTn),
      .we    (op_we && (bus.i_addr_wc == ADDR_W'(k))),
      .strb  (bus.i_strb_wc),
      .d     (bus.i_data_wc),
      .q     (op_q[k])
    );
    assign o_ops[k*DATA_W +: DATA_W] = op_q[k];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_req)      state_nxt = ST_BUSY;
      ST_BUSY:          if (i_result_valid) state_nxt = ST_DONE;
      default:                              state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p1: registered control, pulses and captured result ----
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state     <= ST_IDLE;
      start_p1  <= 1'b0;
      wr_err_p1 <= 1'b0;
      done_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state     <= state_nxt;
      start_p1  <= start_go;
      wr_err_p1 <= wr_err_d;
      if (irq_we) irq_en_q <= bus.i_data_wc[CTRL_IRQEN_BIT];
      if (res_go) result_q <= i_result;
      // Completion outranks a simultaneous clear so a finish is never lost
      if (res_go)                     done_q <= 1'b1;
      else if (start_go || done_w1c)  done_q <= 1'b0;
    end
  end

  assign o_start  = start_p1;
  assign o_wr_err = wr_err_p1;
  assign o_irq    = done_q && irq_en_q;

  always_comb begin
    bus.o_data_rc = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (bus.i_addr_rc == ADDR_W'(k)) bus.o_data_rc = op_q[k];
    end
    if (bus.i_addr_rc == IDX_RESULT) bus.o_data_rc = result_q;
    if (bus.i_addr_rc == IDX_CTRL)   bus.o_data_rc[CTRL_IRQEN_BIT] = irq_en_q;
    if (bus.i_addr_rc == IDX_STATUS) begin
      bus.o_data_rc[STAT_BUSY_BIT] = busy;
      bus.o_data_rc[STAT_DONE_BIT] = done_q;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl_param.sv
// Scoreboard bench for regfile_ctrl_param: two configurations (2x32-bit, 4x64-bit) exercised in turn.
module tb_regfile_ctrl_param;

  logic ACLK  = 1'b0;
  logic ARSTn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        cur   = 1'b0;
  logic        en    = 1'b0;
  logic [31:0] waddr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  strb  = '0;
  logic [31:0] raddr = '0;
  logic        rv    = 1'b0;
  logic [63:0] res   = '0;
  int          nops  = 2;

  regfile_ctrl_param_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
  regfile_ctrl_param_if #(.DATA_W(64), .ADDR_W(32)) if1 ();

  assign if0.i_en_amba_write = en && (cur == 1'b0);
  assign if0.i_addr_wc       = waddr;
  assign if0.i_data_wc       = wdata[31:0];
  assign if0.i_strb_wc       = strb[3:0];
  assign if0.i_addr_rc       = raddr;
  assign if1.i_en_amba_write = en && (cur == 1'b1);
  assign if1.i_addr_wc       = waddr;
  assign if1.i_data_wc       = wdata;
  assign if1.i_strb_wc       = strb;
  assign if1.i_addr_rc       = raddr;

  logic         start0, irq0, err0, start1, irq1, err1;
  logic [63:0]  ops0;
  logic [255:0] ops1;

  regfile_ctrl_param #(.DATA_W(32), .NUM_OPS(2), .ADDR_W(32)) u_dut0 (
    .ACLK(ACLK), .ARSTn(ARSTn), .bus(if0.slave),
    .i_result_valid(rv && (cur == 1'b0)), .i_result(res[31:0]),
    .o_start(start0), .o_ops(ops0), .o_irq(irq0), .o_wr_err(err0));

  regfile_ctrl_param #(.DATA_W(64), .NUM_OPS(4), .ADDR_W(32)) u_dut1 (
    .ACLK(ACLK), .ARSTn(ARSTn), .bus(if1.slave),
    .i_result_valid(rv && (cur == 1'b1)), .i_result(res),
    .o_start(start1), .o_ops(ops1), .o_irq(irq1), .o_wr_err(err1));

  typedef struct {
    string       name;
    int          kind;   // 0 read data, 1 start, 2 wr_err, 3 irq, 4 op0, 5 op1
    logic [63:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  chk_t        mon_e;
  logic [63:0] mon_act;
  int          cyc    = 0;
  int          max_cyc = 100000;

  always @(posedge ACLK) begin
    cyc++;
    if (cyc > max_cyc) begin
      $display("FAIL timeout: wait expired after %0d cycles", cyc);
      $finish;
    end
  end

  always @(negedge ACLK) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        0:       mon_act = cur ? if1.o_data_rc : {32'h0, if0.o_data_rc};
        1:       mon_act = {63'h0, cur ? start1 : start0};
        2:       mon_act = {63'h0, cur ? err1 : err0};
        3:       mon_act = {63'h0, cur ? irq1 : irq0};
        4:       mon_act = cur ? ops1[63:0] : {32'h0, ops0[31:0]};
        default: mon_act = cur ? ops1[127:64] : {32'h0, ops0[63:32]};
      endcase
      n_chk++;
      if (mon_act === mon_e.exp) n_pass++;
      else $display("FAIL cfg%0d %s: got %h expected %h", cur, mon_e.name, mon_act, mon_e.exp);
    end
  end

  task automatic check_now(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic expect_(input string n, input int k, input logic [63:0] v);
    sb.push_back('{n, k, v});
  endtask

  task automatic settle();
    @(negedge ACLK); #1;
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic wr(input int a, input logic [63:0] d, input logic [7:0] s);
    en = 1'b1; waddr = a; wdata = d; strb = s;
    tick();
    en = 1'b0; strb = '0;
  endtask

  task automatic rd(input string n, input int a, input logic [63:0] v);
    raddr = a;
    expect_(n, 0, v);
    settle();
  endtask

  task automatic result(input logic [63:0] v);
    rv = 1'b1; res = v;
    tick();
    rv = 1'b0;
  endtask

  task automatic run_cfg();
    int n;
    n = nops;
    // Reset contents
    expect_("rst_start", 1, 0); expect_("rst_irq", 3, 0); expect_("rst_err", 2, 0);
    settle();
    for (int i = 0; i <= n + 3; i++) rd("rst_read", i, 0);

    // Basic operation
    wr(0, 64'h5, 8'hFF);
    wr(1, 64'h7, 8'hFF);
    rd("op0_rd", 0, 64'h5);
    rd("op1_rd", 1, 64'h7);
    expect_("ops_op0", 4, 64'h5); expect_("ops_op1", 5, 64'h7);
    settle();
    wr(n + 1, 64'h1, 8'hFF);
    expect_("start_pulse", 1, 1); settle();
    tick();
    expect_("start_one_cycle", 1, 0); settle();
    rd("status_busy", n + 2, 64'h1);
    result(64'hC);
    rd("result_c", n, 64'hC);
    rd("status_done", n + 2, 64'h2);
    expect_("irq_masked", 3, 0); settle();

    // Interrupt
    wr(n + 2, 64'h2, 8'hFF);
    wr(n + 1, 64'h2, 8'hFF);
    expect_("irq_no_done", 3, 0); settle();
    rd("ctrl_irqen", n + 1, 64'h2);
    wr(n + 1, 64'h3, 8'hFF);
    result(64'h99);
    expect_("irq_set", 3, 1); settle();
    rd("result_99", n, 64'h99);
    wr(n + 2, 64'h2, 8'hFF);
    expect_("irq_cleared", 3, 0); settle();
    rd("status_w1c", n + 2, 64'h0);

    // Byte strobes
    wr(0, 64'hFFFF_FFFF, 8'hFF);
    wr(0, 64'h1234_5678, 8'h05);
    rd("strb_merge", 0, 64'hFF34_FF78);
    wr(0, 64'h0, 8'h00);
    expect_("strb0_silent", 2, 0); settle();
    rd("strb0_nochange", 0, 64'hFF34_FF78);

    // Writes while busy
    wr(n + 1, 64'h1, 8'hFF);
    expect_("start2_pulse", 1, 1); settle();
    tick();
    wr(1, 64'hAA, 8'hFF);
    expect_("busy_op_err", 2, 1); expect_("busy_op_nostart", 1, 0); settle();
    tick();
    expect_("err_one_cycle", 2, 0); settle();
    wr(n + 1, 64'h1, 8'hFF);
    expect_("busy_start_err", 2, 1); expect_("busy_no_restart", 1, 0); settle();
    rd("op1_unchanged", 1, 64'h7);
    rd("still_busy", n + 2, 64'h1);

    // Collisions and unmapped accesses
    en = 1'b1; waddr = n + 2; wdata = 64'h2; strb = 8'hFF;
    rv = 1'b1; res = 64'h55;
    tick();
    en = 1'b0; strb = '0; rv = 1'b0;
    rd("collide_done", n + 2, 64'h2);
    rd("collide_result", n, 64'h55);
    wr(n + 3, 64'h123, 8'hFF);
    expect_("unmapped_err", 2, 1); settle();
    rd("unmapped_rd", n + 3, 64'h0);
    wr(n, 64'h77, 8'hFF);
    expect_("result_wr_err", 2, 1); settle();
    rd("result_ro", n, 64'h55);
    result(64'h66);
    rd("late_valid_ignored", n, 64'h55);

    // Reset in the middle of an operation
    wr(n + 1, 64'h3, 8'hFF);
    tick();
    ARSTn = 1'b0;
    #1;
    expect_("arst_start", 1, 0); expect_("arst_irq", 3, 0); expect_("arst_err", 2, 0);
    expect_("arst_op0", 4, 0); expect_("arst_op1", 5, 0);
    settle();
    for (int i = 0; i <= n + 3; i++) rd("arst_read", i, 0);
    @(posedge ACLK); #1;
    ARSTn = 1'b1;
    result(64'h66);
    rd("post_rst_result", n, 64'h0);
    rd("post_rst_status", n + 2, 64'h0);
  endtask

  initial begin
    ARSTn = 1'b0;
    repeat (2) tick();
    check_now("init_rst_start0", {63'h0, start0}, 64'h0);
    check_now("init_rst_irq0",   {63'h0, irq0},   64'h0);
    check_now("init_rst_err0",   {63'h0, err0},   64'h0);
    check_now("init_rst_start1", {63'h0, start1}, 64'h0);
    check_now("init_rst_irq1",   {63'h0, irq1},   64'h0);
    check_now("init_rst_err1",   {63'h0, err1},   64'h0);
    ARSTn = 1'b1;
    tick();
    cur = 1'b0; nops = 2;
    run_cfg();
    settle();
    cur = 1'b1; nops = 4;
    run_cfg();
    settle();
    settle();
    if (n_pass != n_chk) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
